// File: rtl/unidade_writeback.sv
// Write-back unit: arbitrates ALU and memory results onto the single register-file write port,
// buffering memory results in a FIFO and tracking pending multi-cycle destinations.
module unidade_writeback #(
  parameter int unsigned PROFUNDIDADE = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            AluValido,
  input  logic [4:0]                      AluEndereco,
  input  logic [31:0]                     AluDado,
  input  logic                            MemValido,
  output logic                            MemPronto,
  input  logic [4:0]                      MemEndereco,
  input  logic [31:0]                     MemDado,
  input  logic                            ReservaValida,
  input  logic [4:0]                      ReservaEndereco,
  input  logic [4:0]                      ConsultaEndereco1,
  input  logic [4:0]                      ConsultaEndereco2,
  output logic                            Ocupado1,
  output logic                            Ocupado2,
  output logic                            EscreveRegistrador,
  output logic [4:0]                      EnderecoEscrita,
  output logic [31:0]                     DadoParaEscrita,
  output logic [$clog2(PROFUNDIDADE):0]   NivelFila
);

  localparam int unsigned LarguraPonteiro = $clog2(PROFUNDIDADE);
  localparam logic [LarguraPonteiro:0] NivelCheio = PROFUNDIDADE[LarguraPonteiro:0];

  logic [4:0]                 filaEndereco [PROFUNDIDADE];
  logic [31:0]                filaDado     [PROFUNDIDADE];
  logic [LarguraPonteiro-1:0] ponteiroLeitura, ponteiroEscrita;
  logic [LarguraPonteiro:0]   nivel;
  logic [31:0]                placar, placarProximo;

  logic filaCheia, aceitaMem, enfileira, selecionaAlu, desenfileira;
  logic [4:0]  cabecaEndereco;
  logic [31:0] cabecaDado;

  assign filaCheia      = (nivel == NivelCheio);
  // Gated by rst_n so the source sees no acceptance while reset is held.
  assign MemPronto      = rst_n && !filaCheia;
  assign aceitaMem      = MemValido && MemPronto;
  assign enfileira      = aceitaMem && (MemEndereco != 5'd0);
  assign selecionaAlu   = AluValido && (AluEndereco != 5'd0);
  assign desenfileira   = !selecionaAlu && (nivel != '0);
  assign cabecaEndereco = filaEndereco[ponteiroLeitura];
  assign cabecaDado     = filaDado[ponteiroLeitura];
  assign NivelFila      = nivel;

  assign Ocupado1 = placar[ConsultaEndereco1];
  assign Ocupado2 = placar[ConsultaEndereco2];

  // Set after clear: a same-edge reservation is younger than the retiring result.
  always_comb begin
    placarProximo = placar;
    if (desenfileira) placarProximo[cabecaEndereco] = 1'b0;
    if (ReservaValida) placarProximo[ReservaEndereco] = 1'b1;
    placarProximo[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (enfileira) begin
      filaEndereco[ponteiroEscrita] <= MemEndereco;
      filaDado[ponteiroEscrita]     <= MemDado;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ponteiroLeitura <= '0;
      ponteiroEscrita <= '0;
      nivel           <= '0;
      placar          <= '0;
    end else begin
      placar <= placarProximo;
      if (enfileira) ponteiroEscrita <= ponteiroEscrita + 1'b1;
      if (desenfileira) ponteiroLeitura <= ponteiroLeitura + 1'b1;
      case ({enfileira, desenfileira})
        2'b10:   nivel <= nivel + 1'b1;
        2'b01:   nivel <= nivel - 1'b1;
        default: nivel <= nivel;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      EscreveRegistrador <= 1'b0;
      EnderecoEscrita    <= 5'd0;
      DadoParaEscrita    <= 32'd0;
    end else begin
      EscreveRegistrador <= selecionaAlu || desenfileira;
      if (selecionaAlu) begin
        EnderecoEscrita <= AluEndereco;
        DadoParaEscrita <= AluDado;
      end else if (desenfileira) begin
        EnderecoEscrita <= cabecaEndereco;
        DadoParaEscrita <= cabecaDado;
      end
    end
  end

endmodule
